// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the bus source FIFO.
//   ptr_w(depth) : pointer width for a power-of-2 depth
//   pkt_t        : packet type at the default bus width of 16 bits. Packages cannot take
//                  parameters, so modules use logic [pckg_sz-1:0] when the width differs.
//   DROP_CNT_W   : width of the dropped-write statistics counter
package bus_fifo_pkg;

  localparam int unsigned DROP_CNT_W    = 16;
  localparam int unsigned PKT_W_DEFAULT = 16;

  typedef logic [PKT_W_DEFAULT-1:0] pkt_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// Register file of depth x pckg_sz entries. It has one synchronous write port and one
// asynchronous read port. The array is not reset, so its contents are undefined until
// each entry is written.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module bus_fifo_mem
  import bus_fifo_pkg::*;
#(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8,
  parameter int unsigned AddrW   = ptr_w(depth)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AddrW-1:0]   waddr_i,
  input  logic [pckg_sz-1:0] wdata_i,
  input  logic [AddrW-1:0]   raddr_i,
  output logic [pckg_sz-1:0] rdata_o
);

  logic [pckg_sz-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_src_fifo.sv
// First-word-fall-through source FIFO for one bus device port. An agent writes packets on
// the write side. The bus watches pndng, reads the head packet on D_pop and consumes it
// with pop.
//   clk, reset        : rising-edge clock; asynchronous active-high reset
//   wr_en, wr_data    : enqueue request and packet
//   full              : depth entries are held
//   pndng, pop, D_pop : head-packet handshake. D_pop is zero when the FIFO is empty.
//   count             : occupancy, from 0 to depth
//   overflow          : one-cycle pulse after a write was dropped
// When the BUS_SRC_FIFO_STATS_EN macro is defined, three saturating traffic counters are
// added: wr_total, pop_total and drop_total.
module bus_src_fifo
  import bus_fifo_pkg::*;
#(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8,
  parameter int unsigned id      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [pckg_sz-1:0]    wr_data,
  output logic                  full,
  output logic                  pndng,
  input  logic                  pop,
  output logic [pckg_sz-1:0]    D_pop,
  output logic [$clog2(depth):0] count,
  output logic                  overflow
`ifdef BUS_SRC_FIFO_STATS_EN
  ,
  output logic [31:0]           wr_total,
  output logic [31:0]           pop_total,
  output logic [DROP_CNT_W-1:0] drop_total
`endif
);

  localparam int unsigned PtrW = ptr_w(depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(depth);

  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               wr_acc, pop_acc, drop;
  logic [pckg_sz-1:0] head;

  assign pndng = (count_q != '0);
  assign full  = (count_q == DepthCnt);

  // A pop on a full FIFO frees the slot that the simultaneous write fills, so the write is
  // accepted.
  assign pop_acc = pop && pndng;
  assign wr_acc  = wr_en && (!full || pop);
  assign drop    = wr_en && full && !pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = drop;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // During a full-FIFO write and pop, wr_ptr equals rd_ptr. The read is asynchronous, so
  // the old head is consumed before the write edge overwrites its slot.
  bus_fifo_mem #(
    .pckg_sz(pckg_sz),
    .depth  (depth),
    .AddrW  (PtrW)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(head)
  );

  assign D_pop    = pndng ? head : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef BUS_SRC_FIFO_STATS_EN
  logic [31:0]           wr_total_q, wr_total_d;
  logic [31:0]           pop_total_q, pop_total_d;
  logic [DROP_CNT_W-1:0] drop_total_q, drop_total_d;

  always_comb begin
    wr_total_d   = wr_total_q;
    pop_total_d  = pop_total_q;
    drop_total_d = drop_total_q;
    if (wr_acc && (wr_total_q != '1)) wr_total_d = wr_total_q + 1'b1;
    if (pop_acc && (pop_total_q != '1)) pop_total_d = pop_total_q + 1'b1;
    if (drop && (drop_total_q != '1)) drop_total_d = drop_total_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_total_q   <= '0;
      pop_total_q  <= '0;
      drop_total_q <= '0;
    end else begin
      wr_total_q   <= wr_total_d;
      pop_total_q  <= pop_total_d;
      drop_total_q <= drop_total_d;
    end
  end

  assign wr_total   = wr_total_q;
  assign pop_total  = pop_total_q;
  assign drop_total = drop_total_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= DepthCnt)
        else $error("bus_src_fifo[%0d]: count %0d exceeds depth", id, count_q);
      assert (pndng == (count_q > '0))
        else $error("bus_src_fifo[%0d]: pndng inconsistent with count", id);
      assert (!(pndng && $isunknown(D_pop)))
        else $error("bus_src_fifo[%0d]: X on D_pop while pending", id);
    end
  end
`endif

endmodule

// File: tb/tb_bus_src_fifo.sv
module tb_bus_src_fifo;
  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        pndng;
  logic        pop;
  logic [15:0] d_pop;
  logic [3:0]  count;
  logic        overflow;
`ifdef BUS_SRC_FIFO_STATS_EN
  logic [31:0] wr_total;
  logic [31:0] pop_total;
  logic [15:0] drop_total;
`endif

  bus_src_fifo #(
    .pckg_sz(16),
    .depth  (Depth),
    .id     (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .pndng   (pndng),
    .pop     (pop),
    .D_pop   (d_pop),
    .count   (count),
    .overflow(overflow)
`ifdef BUS_SRC_FIFO_STATS_EN
    ,
    .wr_total  (wr_total),
    .pop_total (pop_total),
    .drop_total(drop_total)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a packet queue plus the expected overflow pulse and traffic totals
  logic [15:0] q[$];
  logic        ovf_m;
  int unsigned n_wr, n_pop, n_drop;

  function automatic void model_reset();
    q.delete();
    ovf_m  = 1'b0;
    n_wr   = 0;
    n_pop  = 0;
    n_drop = 0;
  endfunction

  function automatic void model_step(input logic w, input logic [15:0] d, input logic p);
    bit was_full  = (q.size() == Depth);
    bit was_empty = (q.size() == 0);
    ovf_m = 1'b0;
    if (w && was_full && !p) begin
      ovf_m = 1'b1;
      n_drop++;
    end
    if (p && !was_empty) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (w && (!was_full || p)) begin
      q.push_back(d);
      n_wr++;
    end
  endfunction

  function automatic logic [15:0] model_head();
    return (q.size() != 0) ? q[0] : 16'h0000;
  endfunction

  // Drive one clock cycle of stimulus; outputs are settled on return (#1 after the edge)
  task automatic cycle(input logic w, input logic [15:0] d, input logic p);
    wr_en   = w;
    wr_data = d;
    pop     = p;
    model_step(w, d, p);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * Depth && q.size() != 0; i++) cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    pop     = 1'b0;
    wr_data = '0;
    model_reset();
    #12;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 16'h0, 1'b0);
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng got %b want 0", pndng); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (d_pop !== 16'h0) begin errors++; $display("FAIL reset_dpop got %h want 0000", d_pop); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
  endtask

  task automatic test_single();
    cycle(1'b1, 16'hA5A5, 1'b0);
    checks++;
    if (pndng !== 1'b1) begin errors++; $display("FAIL single_pndng got %b want 1", pndng); end
    checks++;
    if (d_pop !== 16'hA5A5) begin errors++; $display("FAIL single_dpop got %h want a5a5", d_pop); end
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL single_pop_pndng got %b want 0", pndng); end
    checks++;
    if (d_pop !== 16'h0) begin errors++; $display("FAIL single_pop_dpop got %h want 0000", d_pop); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
    cycle(1'b1, 16'h0009, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", overflow); end
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", count); end
    cycle(1'b0, 16'h0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got %b want 0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (d_pop !== 16'(i)) begin
        errors++;
        $display("FAIL fill_order[%0d] got %h want %h", i, d_pop, 16'(i));
      end
      cycle(1'b0, 16'h0, 1'b1);
    end
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL fill_drained got %b want 0", pndng); end
  endtask

  task automatic test_full_wr_pop();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
    cycle(1'b1, 16'h00FF, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullwp_ovf got %b want 0", overflow); end
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL fullwp_count got %0d want 8", count); end
    for (int i = 1; i <= 8; i++) begin
      logic [15:0] exp;
      exp = (i == 8) ? 16'h00FF : 16'h0100 + 16'(i);
      checks++;
      if (d_pop !== exp) begin
        errors++;
        $display("FAIL fullwp_order[%0d] got %h want %h", i, d_pop, exp);
      end
      cycle(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_empty_pop_wr();
    cycle(1'b1, 16'h1234, 1'b1);
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL emptywp_count got %0d want 1", count); end
    checks++;
    if (d_pop !== 16'h1234) begin errors++; $display("FAIL emptywp_dpop got %h want 1234", d_pop); end
    checks++;
    if (pndng !== 1'b1) begin errors++; $display("FAIL emptywp_pndng got %b want 1", pndng); end
    drain();
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] exp;
      exp = model_head();
      checks++;
      if (d_pop !== exp) begin
        errors++;
        $display("FAIL wrap_order[%0d] got %h want %h", i, d_pop, exp);
      end
      cycle(1'b1, 16'($urandom), 1'b1);
    end
    // Assert reset between edges while a write and pop are being driven
    wr_en   = 1'b1;
    pop     = 1'b1;
    wr_data = 16'hBEEF;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL async_rst_count got %0d want 0", count); end
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL async_rst_pndng got %b want 0", pndng); end
    checks++;
    if (d_pop !== 16'h0) begin errors++; $display("FAIL async_rst_dpop got %h want 0000", d_pop); end
    wr_en = 1'b0;
    pop   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 16'h0, 1'b0);
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL post_rst_count got %0d want 0", count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic w, p;
      // Bias writes slightly so the FIFO visits both full and empty
      w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      p = ($urandom_range(0, 99) < 50);
      cycle(w, 16'($urandom), p);
      checks++;
      if (count !== 4'(q.size())) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d want %0d", i, count, q.size());
      end
      checks++;
      if (d_pop !== model_head()) begin
        errors++;
        $display("FAIL rand_dpop[%0d] got %h want %h", i, d_pop, model_head());
      end
      checks++;
      if (pndng !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_pndng[%0d] got %b want %b", i, pndng, q.size() != 0);
      end
      checks++;
      if (full !== (q.size() == Depth)) begin
        errors++;
        $display("FAIL rand_full[%0d] got %b want %b", i, full, q.size() == Depth);
      end
      checks++;
      if (overflow !== ovf_m) begin
        errors++;
        $display("FAIL rand_ovf[%0d] got %b want %b", i, overflow, ovf_m);
      end
    end
`ifdef BUS_SRC_FIFO_STATS_EN
    checks++;
    if (wr_total !== n_wr) begin errors++; $display("FAIL stat_wr got %0d want %0d", wr_total, n_wr); end
    checks++;
    if (pop_total !== n_pop) begin errors++; $display("FAIL stat_pop got %0d want %0d", pop_total, n_pop); end
    checks++;
    if (drop_total !== 16'(n_drop)) begin
      errors++;
      $display("FAIL stat_drop got %0d want %0d", drop_total, n_drop);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_wr_pop();
    test_empty_pop_wr();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
